// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, tap indexing and output ReLU/saturation for the conv PE
`define CONV_TAP(r, c, k) ((r) * (k) + (c))

package conv_pkg;
    localparam int K_DEF       = 3;
    localparam int PIX_W_DEF   = 8;
    localparam int WGT_W_DEF   = 16;
    localparam int ACC_W_DEF   = 32;
    localparam int GUARD_W_DEF = 8;
    localparam int MAX_CH_DEF  = 512;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } sat_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int prod_w(input int pix_w, input int wgt_w);
        return pix_w + wgt_w + 1;
    endfunction

    function automatic int sum_w(input int pix_w, input int wgt_w, input int k);
        return prod_w(pix_w, wgt_w) + clog2(k * k);
    endfunction

    localparam int PROD_W_DEF = prod_w(PIX_W_DEF, WGT_W_DEF);
    localparam int SUM_W_DEF  = sum_w(PIX_W_DEF, WGT_W_DEF, K_DEF);

    // ReLU first, then clamp to an acc_w-bit signed range; sat flags any clamp
    function automatic sat_t sat_relu(input logic signed [63:0] r, input logic relu, input int acc_w);
        logic signed [63:0] v, hi, lo;
        sat_t o;
        v = (relu && r < 0) ? 64'sd0 : r;
        hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        o.sat = (v > hi) || (v < lo);
        o.val = (v > hi) ? hi : (v < lo) ? lo : v;
        return o;
    endfunction
endpackage

// File: rtl/conv_pe_mac_if.sv
// conv_pe_mac_if: beat input and result output handshake bundle of the conv PE
interface conv_pe_mac_if #(
    parameter int K     = 3,
    parameter int PIX_W = 8,
    parameter int WGT_W = 16,
    parameter int ACC_W = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic [K*K*PIX_W-1:0]   in_pixels;
    logic [K*K*WGT_W-1:0]   in_weights;
    logic [ACC_W-1:0]       bias;
    logic                   relu_en;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_data;
    logic                   out_sat;
    logic                   ch_err;

    modport master (
        output in_valid, in_last, in_pixels, in_weights, bias, relu_en, out_ready,
        input  in_ready, out_valid, out_data, out_sat, ch_err
    );
    modport slave (
        input  in_valid, in_last, in_pixels, in_weights, bias, relu_en, out_ready,
        output in_ready, out_valid, out_data, out_sat, ch_err
    );
endinterface

// File: rtl/conv_adder_tree.sv
// conv_adder_tree: registered signed sum of N products, stalls with the pipeline
module conv_adder_tree
    import conv_pkg::*;
#(
    parameter int N     = K_DEF * K_DEF,
    parameter int IN_W  = PROD_W_DEF,
    parameter int OUT_W = SUM_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [N*IN_W-1:0]       prod_i,
    output logic signed [OUT_W-1:0] sum_o
);
    logic signed [OUT_W-1:0] sum_d, sum_q;

    // Sign-extend every product to the full sum width and add them
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N; i++) sum_d = sum_d + OUT_W'($signed(prod_i[i*IN_W +: IN_W]));
    end

    // Sum register, held while the pipeline is stalled
    always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else if (en_i) sum_q <= sum_d;
    end

    assign sum_o = sum_q;
endmodule

// File: rtl/conv_pe_mac.sv
// conv_pe_mac: KxK multiply-accumulate PE across input channels with bias, ReLU and saturation
module conv_pe_mac
    import conv_pkg::*;
#(
    parameter int K       = K_DEF,
    parameter int PIX_W   = PIX_W_DEF,
    parameter int WGT_W   = WGT_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int GUARD_W = GUARD_W_DEF,
    parameter int MAX_CH  = MAX_CH_DEF
) (
    input logic          clk,
    input logic          rst,
    conv_pe_mac_if.slave bus
);
    localparam int N      = K * K;
    localparam int PROD_W = prod_w(PIX_W, WGT_W);
    localparam int SUM_W  = sum_w(PIX_W, WGT_W, K);
    localparam int AW     = ACC_W + GUARD_W;
    localparam int CW     = clog2(MAX_CH + 1);

    logic                    en;
    logic [N*PROD_W-1:0]     prod_d, prod_q;
    logic                    v1_q, v2_q, last1_q, last2_q, relu1_q, relu2_q;
    logic signed [ACC_W-1:0] bias1_q, bias2_q;
    logic signed [SUM_W-1:0] sum;
    logic signed [AW-1:0]    acc_d, acc_q, r_d;
    logic                    first_q;
    sat_t                    res;
    logic                    ov_q, sat_q, err_q;
    logic [ACC_W-1:0]        out_q;
    logic [CW-1:0]           cnt_q;

    assign en          = !(ov_q && !bus.out_ready);
    assign bus.in_ready = en;

    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            localparam int T = `CONV_TAP(r, c, K);
            logic signed [PROD_W-1:0] p, w;
            assign p = PROD_W'({1'b0, bus.in_pixels[T*PIX_W +: PIX_W]});
            assign w = PROD_W'($signed(bus.in_weights[T*WGT_W +: WGT_W]));
            assign prod_d[T*PROD_W +: PROD_W] = p * w;
        end
    end

    // S1 products and the per-beat sideband flowing alongside S1/S2
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            relu1_q <= 1'b0;
            relu2_q <= 1'b0;
            bias1_q <= '0;
            bias2_q <= '0;
            prod_q  <= '0;
        end else if (en) begin
            v1_q    <= bus.in_valid;
            v2_q    <= v1_q;
            last1_q <= bus.in_last;
            last2_q <= last1_q;
            relu1_q <= bus.relu_en;
            relu2_q <= relu1_q;
            bias1_q <= bus.bias;
            bias2_q <= bias1_q;
            prod_q  <= prod_d;
        end
    end

    conv_adder_tree #(.N(N), .IN_W(PROD_W), .OUT_W(SUM_W)) u_tree (
        .clk   (clk),
        .rst   (rst),
        .en_i  (en),
        .prod_i(prod_q),
        .sum_o (sum)
    );

    // Next accumulator value and the biased, rectified, clamped result
    always_comb begin
        acc_d = first_q ? AW'(sum) : acc_q + AW'(sum);
        r_d   = acc_d + AW'(bias2_q);
        res   = sat_relu(64'(r_d), relu2_q, ACC_W);
    end

    // S3 accumulator and output register; a last beat restarts the group
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            first_q <= 1'b1;
            ov_q    <= 1'b0;
            out_q   <= '0;
            sat_q   <= 1'b0;
        end else if (en) begin
            ov_q <= v2_q && last2_q;
            if (v2_q) begin
                acc_q   <= acc_d;
                first_q <= last2_q;
                if (last2_q) begin
                    out_q <= ACC_W'(res.val);
                    sat_q <= res.sat;
                end
            end
        end
    end

    // Beats per group, saturating at MAX_CH; ch_err sticks until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (en && bus.in_valid) begin
            cnt_q <= bus.in_last ? '0 : (cnt_q == CW'(MAX_CH)) ? cnt_q : cnt_q + 1'b1;
            err_q <= err_q || (!bus.in_last && cnt_q >= CW'(MAX_CH - 1));
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.out_data  = out_q;
    assign bus.out_sat   = sat_q;
    assign bus.ch_err    = err_q;
endmodule

// File: tb/tb_conv_pe_mac.sv
// tb_conv_pe_mac: directed scoreboard bench for the conv PE
module tb_conv_pe_mac;
    localparam int K     = 3;
    localparam int N     = K * K;
    localparam int PIX_W = 8;
    localparam int WGT_W = 16;
    localparam int ACC_W = 32;

    typedef struct {
        longint d;
        bit     s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_pe_mac_if #(.K(K), .PIX_W(PIX_W), .WGT_W(WGT_W), .ACC_W(ACC_W)) ifc ();

    conv_pe_mac #(
        .K(K), .PIX_W(PIX_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .GUARD_W(8), .MAX_CH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    exp_t             q[$];
    int               errors = 0;
    int               checks = 0;
    longint           acc_m  = 0;
    bit               first_m = 1'b1;
    logic             stall_p = 1'b0;
    logic [ACC_W-1:0] data_p  = '0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [N*PIX_W-1:0] pfill(input logic [PIX_W-1:0] p);
        return {N{p}};
    endfunction

    function automatic logic [N*WGT_W-1:0] wfill(input logic [WGT_W-1:0] w);
        return {N{w}};
    endfunction

    // Drive one beat, wait for acceptance, and update the reference model
    task automatic beat(input logic [N*PIX_W-1:0] px, input logic [N*WGT_W-1:0] wt,
                        input bit last, input longint b, input bit relu);
        longint s = 0;
        longint r;
        int g = 0;
        exp_t e;
        ifc.in_valid   = 1'b1;
        ifc.in_pixels  = px;
        ifc.in_weights = wt;
        ifc.in_last    = last;
        ifc.bias       = b[ACC_W-1:0];
        ifc.relu_en    = relu;
        while (!ifc.in_ready && g < 200) begin
            step();
            g++;
        end
        chk("in_ready", ifc.in_ready, 1);
        for (int i = 0; i < N; i++)
            s += longint'(px[i*PIX_W +: PIX_W]) * longint'($signed(wt[i*WGT_W +: WGT_W]));
        acc_m   = first_m ? s : acc_m + s;
        first_m = last;
        if (last) begin
            r = acc_m + b;
            if (relu && r < 0) r = 0;
            e.s = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            e.d = (r > 64'sd2147483647) ? 64'sd2147483647 : (r < -64'sd2147483648) ? -64'sd2147483648 : r;
            q.push_back(e);
        end
        step();
        ifc.in_valid = 1'b0;
    endtask

    // Output monitor: hold stability under backpressure and in-order scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ifc.out_valid && stall_p) chk("hold", $signed(ifc.out_data), $signed(data_p));
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            if (q.size() == 0) chk("spurious_out", ifc.out_valid, 0);
            else begin
                e = q.pop_front();
                chk("out_data", $signed(ifc.out_data), e.d);
                chk("out_sat", ifc.out_sat, e.s);
            end
        end
        stall_p = !rst && ifc.out_valid && !ifc.out_ready;
        data_p  = ifc.out_data;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [N*PIX_W-1:0] px;
        logic [N*WGT_W-1:0] wt;
        ifc.in_valid   = 1'b0;
        ifc.in_last    = 1'b0;
        ifc.in_pixels  = '0;
        ifc.in_weights = '0;
        ifc.bias       = '0;
        ifc.relu_en    = 1'b0;
        ifc.out_ready  = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_out_data", ifc.out_data, 0);
        chk("rst_out_sat", ifc.out_sat, 0);
        chk("rst_ch_err", ifc.ch_err, 0);
        chk("rst_in_ready", ifc.in_ready, 1);

        beat(pfill(8'd1), wfill(16'd2), 1'b1, 5, 1'b0);
        chk("lat_t1", ifc.out_valid, 0);
        step();
        chk("lat_t2", ifc.out_valid, 0);
        step();
        chk("lat_t3", ifc.out_valid, 1);
        chk("t1_data", $signed(ifc.out_data), 23);
        step(2);

        beat(pfill(8'd255), wfill(16'hFFFF), 1'b0, 0, 1'b0);
        beat(pfill(8'd255), wfill(16'hFFFF), 1'b1, 0, 1'b0);
        beat(pfill(8'd255), wfill(16'hFFFF), 1'b0, 0, 1'b1);
        beat(pfill(8'd255), wfill(16'hFFFF), 1'b1, 0, 1'b1);
        for (int i = 0; i < N; i++) begin
            px[i*PIX_W +: PIX_W] = 8'(i + 1);
            wt[i*WGT_W +: WGT_W] = 16'(i - 4);
        end
        beat(px, wt, 1'b1, -100, 1'b0);
        step(5);

        ifc.out_ready = 1'b0;
        beat(pfill(8'd2), wfill(16'd3), 1'b1, 0, 1'b0);
        beat(pfill(8'd3), wfill(16'd3), 1'b1, 1, 1'b0);
        beat(pfill(8'd4), wfill(16'hFFFB), 1'b1, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", ifc.in_ready, 0);
            chk("bp_out_valid", ifc.out_valid, 1);
            step();
        end
        ifc.out_ready = 1'b1;
        step(8);
        chk("bp_drained", q.size(), 0);

        for (int i = 0; i < 3; i++) beat(pfill(8'd7), wfill(16'd7), 1'b0, 0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        first_m = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_no_out", ifc.out_valid, 0);
            step();
        end
        beat(pfill(8'd1), wfill(16'd1), 1'b1, 0, 1'b0);
        step(4);
        chk("rst_grp_err", ifc.ch_err, 0);

        for (int i = 0; i < 3; i++) beat(pfill(8'd1), wfill(16'd1), 1'b0, 0, 1'b0);
        chk("ch_err_3", ifc.ch_err, 0);
        beat(pfill(8'd1), wfill(16'd1), 1'b0, 0, 1'b0);
        chk("ch_err_4", ifc.ch_err, 1);
        beat(pfill(8'd1), wfill(16'd1), 1'b0, 0, 1'b0);
        chk("ch_err_5", ifc.ch_err, 1);
        beat(pfill(8'd1), wfill(16'd1), 1'b1, 0, 1'b0);
        step(4);
        chk("ch_err_sticky", ifc.ch_err, 1);

        for (int i = 0; i < 29; i++) beat(pfill(8'd255), wfill(16'd32767), i == 28, 0, 1'b0);
        for (int i = 0; i < 29; i++) beat(pfill(8'd255), wfill(16'h8000), i == 28, 0, 1'b0);
        step(6);
        chk("final_drained", q.size(), 0);
        chk("ch_err_hold", ifc.ch_err, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ch_err_cleared", ifc.ch_err, 0);
        chk("end_out_valid", ifc.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv_pe_mac.md
Name: conv_pe_mac

Overview:
Parametrised successor to the fixed 3x3 per-tap multiplier PE. It takes one KxK pixel window and KxK weight window per beat, with one input channel per beat, and multiplies and sums all taps. It accumulates across input channels until the beat marked last, then adds a bias, optionally applies ReLU, and saturates to the output width. The block sits between the line-buffer/weight-fetch front end and the output-channel writeback. It uses valid/ready handshakes on both sides.

Parameters:
K, 3, kernel side length; K*K taps
PIX_W, 8, pixel width, unsigned
WGT_W, 16, weight width, signed two's complement
ACC_W, 32, output and bias width, signed
GUARD_W, 8, extra accumulator guard bits
MAX_CH, 512, beats allowed per accumulation group before error

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_last  in  1  beat is the final input channel of the group
in_pixels  in  K*K*PIX_W  window, flattened; tap (r,c) at index r*K+c, tap 0 in LSBs
in_weights  in  K*K*WGT_W  weights, same tap order
bias  in  ACC_W  signed bias; sampled on the beat with in_last=1
relu_en  in  1  ReLU mode; sampled on the beat with in_last=1
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_data  out  ACC_W  signed result
out_sat  out  1  out_data was clamped
ch_err  out  1  sticky; group exceeded MAX_CH beats

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all stage valids=0, accumulator=0, beat counter=0, first-beat flag=1. out_valid=0, out_data=0, out_sat=0, ch_err=0. in_ready=1 in the cycle after reset.
- Handshake: a beat transfers when in_valid&in_ready. A result transfers when out_valid&out_ready.
- Global stall: en = !(out_valid & !out_ready). in_ready = en.
- When en=0, every stage holds its state.
- out_data is stable while out_valid=1 and out_ready=0.
- S1 (multiply): register K*K products.
  - Each pixel is zero-extended to PIX_W+1 bits, then multiplied signed by its weight.
  - Product width is PIX_W+WGT_W+1.
- S2 (sum): register the adder-tree sum of the products, sign-extended, width PIX_W+WGT_W+1+clog2(K*K).
- S3 (accumulate): internal accumulator width ACC_W+GUARD_W.
  - First beat of a group: acc = sum.
  - Later beats: acc = acc + sum.
  - The in_last flag, bias and relu_en travel down the pipeline with the beat.
- On a last beat, S3 computes r = acc_next + sext(bias). r then goes through:
  - ReLU: if relu_en and r<0, r=0.
  - Saturation: clamp r to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. out_sat=1 iff clamping occurred.
  - Output register: out_data loads the result, out_valid=1, and the first-beat flag is set.
- Latency: a last beat accepted in cycle t gives out_valid=1 in cycle t+3 when there is no stall. Throughput is one beat per cycle.
- Back-to-back results: if out_valid&out_ready and S3 produces a new result in the same cycle, the new result loads with no bubble.
- Single-channel group (in_last on the first beat): result = sum + bias.
- Beat counter:
  - Increments per accepted beat and clears on an accepted last beat.
  - If an accepted non-last beat would make the count reach MAX_CH, set ch_err=1.
  - Accumulation continues after ch_err is set; the counter saturates.
  - ch_err clears only on rst.
- Reset mid-operation: in-flight beats and any partial accumulation are discarded. No out_valid pulse follows.
- The accumulator does not wrap internally; the guard bits must cover the magnitude. Saturation happens only at output.

Decomposition:
- Shared package conv_pkg holds:
  - localparams for the product and sum widths, and the clog2 helper
  - the saturate/ReLU function
  - the tap-index macro r*K+c
- One natural sub-module: conv_adder_tree, a parametrised registered K*K-input signed adder tree (S2).
- Multiply, accumulate, counter and output register stay in conv_pe_mac.

Test Plan:
- K=3, all pixels=1, weights=2, bias=5, in_last=1, relu_en=0 -> out_data=23 at t+3, out_sat=0.
- Two beats, pixels=255, weights=-1, bias=0, relu_en=0 -> out_data=-4590. Repeat with relu_en=1 -> out_data=0.
- 29 beats of pixels=255, weights=32767, bias=0 -> after 28 beats acc=2105607420; final out_data=2147483647, out_sat=1.
- out_ready held 0 for 5 cycles with results queued -> in_ready=0, out_data stable. On release, each result is delivered exactly once, in order.
- Assert rst mid-group after 3 beats, then send a single last beat (pixels=1, weights=1, bias=0) -> out_data=9; the earlier beats do not contribute.
- MAX_CH=4, send 5 non-last beats -> ch_err=1 on the 4th beat and stays 1 until rst.
